// File: rtl/ddr_pkg.sv
// Shared types and constants for the dual-edge transmit scheduler.
// Holds the FSM state encoding, the source index type and the beat-counter sizing helper.
package ddr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;

    typedef logic src_t;

    // Beat counter width: clog2 of beats per word, never narrower than one bit.
    function automatic int beat_w(input int data_w);
        return (data_w / 2 > 1) ? $clog2(data_w / 2) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// The priority pointer lives in the caller; this block only resolves ties with it.
module rr_arb2
    import ddr_pkg::*;
(
    input  logic [1:0] valid,
    input  src_t       prio,
    output logic       grant_valid,
    output src_t       grant_idx
);

    always_comb begin
        grant_valid = |valid;
        grant_idx   = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = prio;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ddr_tx_scheduler.sv
// Arbitrates two word sources and serializes each granted word MSB-first,
// two bits per clock, toward the dual-edge output flop pair.
module ddr_tx_scheduler
    import ddr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              d_rise,
    output logic              d_fall,
    output logic              tx_active,
    output logic              tx_src,
    output logic              tx_last
);

    localparam int BW = beat_w(DATA_W);
    localparam logic [BW-1:0] LAST_BEAT = BW'(DATA_W / 2 - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     beat_q,  beat_d;
    src_t              prio_q,  prio_d;
    src_t              src_q,   src_d;

    logic grant_valid;
    src_t grant_idx;
    logic accept;

    rr_arb2 u_arb (
        .valid       ({req1_valid, req0_valid}),
        .prio        (prio_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Ready is withheld while reset is high so reset always wins over a handshake.
    assign accept     = (state_q == IDLE) && !reset && grant_valid;
    assign req0_ready = accept && (grant_idx == 1'b0);
    assign req1_ready = accept && (grant_idx == 1'b1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        beat_d  = beat_q;
        prio_d  = prio_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = grant_idx ? req1_data : req0_data;
                    beat_d  = '0;
                    src_d   = grant_idx;
                    prio_d  = ~grant_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                shreg_d = shreg_q << 2;
                beat_d  = beat_q + 1'b1;
                if (beat_q == LAST_BEAT)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            prio_q  <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
        end
    end

    assign tx_active = (state_q == SEND);
    assign d_rise    = tx_active && shreg_q[DATA_W-1];
    assign d_fall    = tx_active && shreg_q[DATA_W-2];
    assign tx_last   = tx_active && (beat_q == LAST_BEAT);
    assign tx_src    = src_q;

endmodule

// File: tb/tb_ddr_tx_scheduler.sv
// Directed bench for ddr_tx_scheduler: an 8-bit instance for the main scenarios
// and a 2-bit instance for the single-beat word case.
module tb_ddr_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0v, r1v;
    logic [7:0] r0d, r1d;
    logic       r0rdy, r1rdy, d_rise, d_fall, tx_active, tx_src, tx_last;

    logic       s0v, s1v;
    logic [1:0] s0d, s1d;
    logic       s0rdy, s1rdy, d_rise2, d_fall2, tx_active2, tx_src2, tx_last2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_tx_scheduler #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0rdy),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1rdy),
        .d_rise(d_rise), .d_fall(d_fall), .tx_active(tx_active),
        .tx_src(tx_src), .tx_last(tx_last)
    );

    ddr_tx_scheduler #(.DATA_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(s0v), .req0_data(s0d), .req0_ready(s0rdy),
        .req1_valid(s1v), .req1_data(s1d), .req1_ready(s1rdy),
        .d_rise(d_rise2), .d_fall(d_fall2), .tx_active(tx_active2),
        .tx_src(tx_src2), .tx_last(tx_last2)
    );

    // {tx_active, tx_last, tx_src, d_rise, d_fall, req0_ready, req1_ready}
    wire [6:0] obs = {tx_active, tx_last, tx_src, d_rise, d_fall, r0rdy, r1rdy};

    function automatic logic [6:0] exp_beat(input logic [7:0] w, input int b, input logic s);
        return {1'b1, (b == 3), s, w[7-2*b], w[6-2*b], 2'b00};
    endfunction

    function automatic logic [6:0] exp_idle(input logic s, input logic rdy0, input logic rdy1);
        return {2'b00, s, 2'b00, rdy0, rdy1};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        r0v = 0; r1v = 0; r0d = '0; r1d = '0;
        s0v = 0; s1v = 0; s0d = '0; s1d = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r0v = 0; r1v = 1; r0d = '0; r1d = 8'hEE;
        s0v = 0; s1v = 0; s0d = '0; s1d = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b exp %b", obs, 7'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0; r1v = 0;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++; $display("FAIL reset_no_accept: got %b exp %b", obs, 7'b0);
        end
        checks++;
        if ({tx_active2, tx_last2, tx_src2, d_rise2, d_fall2, s0rdy, s1rdy} !== 7'b0) begin
            errors++; $display("FAIL reset_dw2: got %b exp 0", {tx_active2, tx_last2, tx_src2, d_rise2, d_fall2, s0rdy, s1rdy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [6:0] e;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            r0v = (c == 0); r0d = 8'hA5;
            @(negedge clk);
            e = (c == 0) ? exp_idle(1'b0, 1'b1, 1'b0) :
                (c == 5) ? exp_idle(1'b0, 1'b0, 1'b0) : exp_beat(8'hA5, c - 1, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL single_word c%0d: got %b exp %b", c, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_tie();
        logic [6:0] e;
        do_reset();
        r0d = 8'hFF; r1d = 8'h00;
        for (int c = 0; c < 11; c++) begin
            r0v = (c == 0) || (c == 10);
            r1v = (c <= 5) || (c == 10);
            @(negedge clk);
            if (c == 0)       e = exp_idle(1'b0, 1'b1, 1'b0);
            else if (c < 5)   e = exp_beat(8'hFF, c - 1, 1'b0);
            else if (c == 5)  e = exp_idle(1'b0, 1'b0, 1'b1);
            else if (c < 10)  e = exp_beat(8'h00, c - 6, 1'b1);
            else              e = exp_idle(1'b1, 1'b1, 1'b0);  // prio back at 0
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL tie c%0d: got %b exp %b", c, obs, e);
            end
            if (c == 10) begin r0v = 0; r1v = 0; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e;
        do_reset();
        r0d = 8'h3C; r1d = 8'h81;
        r0v = 1; r1v = 1;
        for (int c = 0; c < 20; c++) begin
            int   k = c / 5;
            int   p = c % 5;
            logic s = k[0];
            @(negedge clk);
            if (p == 0) e = exp_idle((k == 0) ? 1'b0 : ~s, ~s, s);
            else        e = exp_beat(s ? 8'h81 : 8'h3C, p - 1, s);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL alternation c%0d: got %b exp %b", c, obs, e);
            end
            @(posedge clk); #1;
        end
        r0v = 0; r1v = 0;
    endtask

    task automatic test_lone_requester();
        logic [6:0] e;
        logic [7:0] w;
        do_reset();
        r1v = 1;
        for (int c = 0; c < 15; c++) begin
            int k = c / 5;
            int p = c % 5;
            w = 8'h12 + 8'(k * 8'h22);
            if (p == 0) r1d = w;
            @(negedge clk);
            if (p == 0) e = exp_idle((k == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1);
            else        e = exp_beat(w, p - 1, 1'b1);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL lone c%0d: got %b exp %b", c, obs, e);
            end
            @(posedge clk); #1;
        end
        r1v = 0;
    endtask

    task automatic test_reset_mid_send();
        logic [6:0] e;
        do_reset();
        r0d = 8'hC3; r1d = 8'h5A;
        for (int c = 0; c < 10; c++) begin
            r0v = (c == 0);
            r1v = (c >= 1) && (c <= 4);
            reset = (c == 3);
            @(negedge clk);
            if (c == 0)      e = exp_idle(1'b0, 1'b1, 1'b0);
            else if (c < 4)  e = exp_beat(8'hC3, c - 1, 1'b0);
            else if (c == 4) e = exp_idle(1'b0, 1'b0, 1'b1);
            else if (c < 9)  e = exp_beat(8'h5A, c - 5, 1'b1);
            else             e = exp_idle(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_mid_send c%0d: got %b exp %b", c, obs, e);
            end
            @(posedge clk); #1;
        end
        reset = 0;
    endtask

    task automatic test_dw2();
        logic [6:0] e;
        logic [6:0] o;
        do_reset();
        s0d = 2'b10;
        for (int c = 0; c < 3; c++) begin
            s0v = (c == 0);
            @(negedge clk);
            o = {tx_active2, tx_last2, tx_src2, d_rise2, d_fall2, s0rdy, s1rdy};
            e = (c == 0) ? 7'b0000010 : (c == 1) ? 7'b1101000 : 7'b0000000;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL dw2 c%0d: got %b exp %b", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_tie();
        test_back_to_back();
        test_lone_requester();
        test_reset_mid_send();
        test_dw2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
